fmul_arbiter: RTL and testbench

Round-robin scheduler that shares one single-precision floating-point multiplier among NUM_REQ requesters. Accepts operand pairs over per-requester valid/ready handshakes, issues at most one multiply per cycle into the fixed-latency multiplier, and tracks each issued operation's owner and exception flags through the pipeline. It returns the result to the owning requester exactly MUL_LAT cycles after issue. A quiesce input drains the pipeline for reconfiguration or clock gating.

---
 rtl/fmul_arb_pkg.sv | 27 ++
 rtl/fmul_rr_pick.sv | 39 +++
 rtl/fmul_arbiter.sv | 179 +++++++++++++++++
 tb/tb_fmul_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmul_arb_pkg.sv
// Shared types for the floating-point multiplier arbiter: FSM states, the
// in-flight pipeline entry and the zero-operand helper.
package fmul_arb_pkg;

  localparam int FP32_W  = 32;
  // Wide enough for the largest supported requester count (8).
  localparam int OWNER_W = 3;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALT
  } state_e;

  typedef struct packed {
    logic               valid;
    logic [OWNER_W-1:0] owner;
    logic               uf;
    logic               of;
  } inflight_t;

  // True for +0 and -0: everything except the sign bit is clear.
  function automatic logic is_zero(input logic [FP32_W-1:0] fp32);
    return fp32[FP32_W-2:0] == '0;
  endfunction

endpackage

// File: rtl/fmul_rr_pick.sv
// Combinational round-robin select: first asserted request at or above ptr,
// wrapping around, reported as a one-hot grant plus its index.
module fmul_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // NOTE: every output and temporary gets a default before the search loop so
  // no path through this always_comb leaves a value held, which would infer a latch.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(N)) begin
        sum = sum - (IDX_W + 1)'(N);
      end
      cand = sum[IDX_W-1:0];
      if (!any && req[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fmul_arbiter.sv
// Round-robin scheduler sharing one fixed-latency FP32 multiplier among
// NUM_REQ requesters. Optional sticky flag outputs with FMUL_ARB_STICKY_EN.
module fmul_arbiter
  import fmul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [FP32_W*NUM_REQ-1:0] req_a,
  input  logic [FP32_W*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [FP32_W-1:0]         resp_data,
  output logic                      resp_uf,
  output logic                      resp_of,
  output logic [FP32_W-1:0]         mul_a,
  output logic [FP32_W-1:0]         mul_b,
  input  logic [FP32_W-1:0]         mul_product,
  input  logic                      mul_underflow,
  input  logic                      mul_overflow,
  input  logic                      quiesce,
`ifdef FMUL_ARB_STICKY_EN
  input  logic [NUM_REQ-1:0]        sticky_clr,
  output logic [NUM_REQ-1:0]        sticky_uf,
  output logic [NUM_REQ-1:0]        sticky_of,
`endif
  output logic                      idle
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MUL_LAT + 1);

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  inflight_t         pipe_q [MUL_LAT];
  inflight_t         pipe_d [MUL_LAT];

  logic [FP32_W-1:0] op_a [NUM_REQ];
  logic [FP32_W-1:0] op_b [NUM_REQ];
  logic [NUM_REQ-1:0] pick_req;
  logic [NUM_REQ-1:0] pick_grant;
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_any;
  logic              zero_op;
  logic [CNT_W-1:0]  inflight_cnt;
  inflight_t         issue_e;
  inflight_t         tail_e;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_ops
    assign op_a[g] = req_a[FP32_W*g +: FP32_W];
    assign op_b[g] = req_b[FP32_W*g +: FP32_W];
  end

  // Arbitration is only enabled in RUN; DRAIN and HALT see an empty request set.
  assign pick_req = (state_q == RUN) ? req_valid : '0;

  fmul_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (PTR_W)
  ) u_pick (
    .req   (pick_req),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign req_ready = pick_grant;
  assign mul_a     = pick_any ? op_a[pick_idx] : '0;
  assign mul_b     = pick_any ? op_b[pick_idx] : '0;

  // Multiplier flags lead the product, so they are captured at issue time.
  always_comb begin
    zero_op = is_zero(mul_a) || is_zero(mul_b);
    issue_e = '{valid: pick_any,
                owner: OWNER_W'(pick_idx),
                uf:    pick_any && !zero_op && mul_underflow,
                of:    pick_any && !zero_op && mul_overflow};
  end

  always_comb begin
    pipe_d[0] = issue_e;
    for (int k = 1; k < MUL_LAT; k++) begin
      pipe_d[k] = pipe_q[k-1];
    end
  end

  always_comb begin
    inflight_cnt = '0;
    for (int k = 0; k < MUL_LAT; k++) begin
      inflight_cnt = inflight_cnt + CNT_W'(pipe_q[k].valid);
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (pick_any) begin
      ptr_d = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (quiesce) state_d = DRAIN;
      DRAIN: begin
        if (!quiesce) begin
          state_d = RUN;
        end else if (inflight_cnt == '0) begin
          state_d = HALT;
        end
      end
      HALT:    if (!quiesce) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // NOTE: the whole pipeline is reset, not just held, because a stale valid
  // bit after reset would emit a response for an operation that was discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      ptr_q   <= '0;
      for (int k = 0; k < MUL_LAT; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments let every stage sample its predecessor's
      // pre-edge value, so the shift register moves exactly one slot per clock.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      for (int k = 0; k < MUL_LAT; k++) begin
        pipe_q[k] <= pipe_d[k];
      end
    end
  end

  assign tail_e = pipe_q[MUL_LAT-1];

  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid[i] = tail_e.valid && (tail_e.owner == OWNER_W'(i));
    end
    resp_data = tail_e.valid ? mul_product : '0;
    resp_uf   = tail_e.valid && tail_e.uf;
    resp_of   = tail_e.valid && tail_e.of;
  end

  assign idle = (state_q == HALT);

`ifdef FMUL_ARB_STICKY_EN
  logic [NUM_REQ-1:0] sticky_uf_q, sticky_uf_d;
  logic [NUM_REQ-1:0] sticky_of_q, sticky_of_d;

  // Set is applied after clear so a same-cycle set wins.
  always_comb begin
    sticky_uf_d = (sticky_uf_q & ~sticky_clr) | (resp_uf ? resp_valid : '0);
    sticky_of_d = (sticky_of_q & ~sticky_clr) | (resp_of ? resp_valid : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_uf_q <= '0;
      sticky_of_q <= '0;
    end else begin
      sticky_uf_q <= sticky_uf_d;
      sticky_of_q <= sticky_of_d;
    end
  end

  assign sticky_uf = sticky_uf_q;
  assign sticky_of = sticky_of_q;
`endif

endmodule

// File: tb/tb_fmul_arbiter.sv
// Self-checking bench for fmul_arbiter: a MUL_LAT=3 instance for most scenarios
// plus a MUL_LAT=1 instance for the single-request latency case.
module tb_fmul_arbiter;

  localparam int N   = 4;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Main instance (MUL_LAT = 3)
  logic [N-1:0]    req_valid, req_ready, resp_valid;
  logic [32*N-1:0] req_a, req_b;
  logic [31:0]     resp_data, mul_a, mul_b, mul_product;
  logic            resp_uf, resp_of, mul_uf, mul_of, quiesce, idle;

  // Latency-1 instance
  logic [N-1:0]    l1_req_valid, l1_req_ready, l1_resp_valid;
  logic [32*N-1:0] l1_req_a, l1_req_b;
  logic [31:0]     l1_resp_data, l1_mul_a, l1_mul_b, l1_mul_product;
  logic            l1_resp_uf, l1_resp_of, l1_mul_uf, l1_mul_of, l1_idle;

`ifdef FMUL_ARB_STICKY_EN
  logic [N-1:0] sticky_clr, sticky_uf, sticky_of;
  logic [N-1:0] l1_sticky_clr, l1_sticky_uf, l1_sticky_of;
`endif

  // Simplified FP32 multiplier: flush-to-zero on zero/denormal inputs (raising
  // underflow), truncating rounding. Returns {uf, of, product}.
  function automatic logic [33:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          e;
    logic [47:0] m;
    logic [22:0] frac;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {2'b10, s, 31'd0};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    if (m[47]) begin
      frac = m[46:24];
      e++;
    end else begin
      frac = m[45:23];
    end
    if (e >= 255) return {2'b01, s, 8'hFF, 23'd0};
    if (e <= 0) return {2'b10, s, 31'd0};
    return {2'b00, s, e[7:0], frac};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(3))
      0:       rand_op = r;
      1:       rand_op = {r[31], 8'(120 + $urandom_range(15)), r[22:0]};
      2:       rand_op = {r[31], 8'(200 + $urandom_range(54)), r[22:0]};
      default: rand_op = {r[31], 8'($urandom_range(2)), ($urandom_range(1) == 0) ? 23'd0 : r[22:0]};
    endcase
  endfunction

  // Multiplier models: flags combinational, product delayed by the latency.
  logic [33:0] mul_now, l1_mul_now;
  logic [31:0] prod_pipe [LAT];
  logic [31:0] l1_prod_q;

  assign mul_now    = fp_mul(mul_a, mul_b);
  assign mul_uf     = mul_now[33];
  assign mul_of     = mul_now[32];
  assign l1_mul_now = fp_mul(l1_mul_a, l1_mul_b);
  assign l1_mul_uf  = l1_mul_now[33];
  assign l1_mul_of  = l1_mul_now[32];

  always @(posedge clk) begin
    prod_pipe[0] <= mul_now[31:0];
    for (int k = 1; k < LAT; k++) prod_pipe[k] <= prod_pipe[k-1];
    l1_prod_q <= l1_mul_now[31:0];
  end
  assign mul_product    = prod_pipe[LAT-1];
  assign l1_mul_product = l1_prod_q;

  fmul_arbiter #(.NUM_REQ(N), .MUL_LAT(LAT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .resp_uf       (resp_uf),
    .resp_of       (resp_of),
    .mul_a         (mul_a),
    .mul_b         (mul_b),
    .mul_product   (mul_product),
    .mul_underflow (mul_uf),
    .mul_overflow  (mul_of),
    .quiesce       (quiesce),
`ifdef FMUL_ARB_STICKY_EN
    .sticky_clr    (sticky_clr),
    .sticky_uf     (sticky_uf),
    .sticky_of     (sticky_of),
`endif
    .idle          (idle)
  );

  fmul_arbiter #(.NUM_REQ(N), .MUL_LAT(1)) dut_l1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (l1_req_valid),
    .req_ready     (l1_req_ready),
    .req_a         (l1_req_a),
    .req_b         (l1_req_b),
    .resp_valid    (l1_resp_valid),
    .resp_data     (l1_resp_data),
    .resp_uf       (l1_resp_uf),
    .resp_of       (l1_resp_of),
    .mul_a         (l1_mul_a),
    .mul_b         (l1_mul_b),
    .mul_product   (l1_mul_product),
    .mul_underflow (l1_mul_uf),
    .mul_overflow  (l1_mul_of),
    .quiesce       (1'b0),
`ifdef FMUL_ARB_STICKY_EN
    .sticky_clr    (l1_sticky_clr),
    .sticky_uf     (l1_sticky_uf),
    .sticky_of     (l1_sticky_of),
`endif
    .idle          (l1_idle)
  );

  typedef struct {
    int          due;
    logic [N-1:0] owner1h;
    logic [31:0] data;
    logic        uf;
    logic        of;
  } exp_t;

  task automatic test_reset();
    rst_n = 1'b0; quiesce = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0;
    l1_req_valid = '0; l1_req_a = '0; l1_req_b = '0;
`ifdef FMUL_ARB_STICKY_EN
    sticky_clr = '0; l1_sticky_clr = '0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    n_checks++; if (resp_valid !== '0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0000", resp_valid); end
    n_checks++; if (resp_data !== '0) begin n_fail++; $display("FAIL reset_resp_data: got %h expected 0", resp_data); end
    n_checks++; if ({resp_uf, resp_of} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b expected 00", {resp_uf, resp_of}); end
    n_checks++; if ({mul_a, mul_b} !== 64'd0) begin n_fail++; $display("FAIL reset_mul_ops: got %h expected 0", {mul_a, mul_b}); end
    n_checks++; if (idle !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got %b expected 0", idle); end
    n_checks++; if (l1_resp_valid !== '0) begin n_fail++; $display("FAIL reset_l1_resp_valid: got %b expected 0000", l1_resp_valid); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single_lat1();
    l1_req_a[64 +: 32] = 32'h3F80_0000;
    l1_req_b[64 +: 32] = 32'h3F80_0000;
    l1_req_valid = 4'b0100;
    @(negedge clk);
    n_checks++; if (l1_req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b expected 0100", l1_req_ready); end
    n_checks++; if (l1_resp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_early_resp: got %b expected 0000", l1_resp_valid); end
    @(posedge clk); #1;
    l1_req_valid = '0;
    @(negedge clk);
    n_checks++; if (l1_resp_valid !== 4'b0100) begin n_fail++; $display("FAIL single_resp_valid: got %b expected 0100", l1_resp_valid); end
    n_checks++; if (l1_resp_data !== 32'h3F80_0000) begin n_fail++; $display("FAIL single_resp_data: got %h expected 3f800000", l1_resp_data); end
    n_checks++; if ({l1_resp_uf, l1_resp_of} !== 2'b00) begin n_fail++; $display("FAIL single_flags: got %b expected 00", {l1_resp_uf, l1_resp_of}); end
    @(posedge clk); #1;
    n_checks++; if (l1_resp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_resp_once: got %b expected 0000", l1_resp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0]  exp_d [N];
    logic [N-1:0] exp_g, exp_r;
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = {1'b0, 8'(127 + i), 23'($urandom)};
      req_b[32*i +: 32] = {1'b0, 8'd126, 23'($urandom)};
      exp_d[i] = fp_mul(req_a[32*i +: 32], req_b[32*i +: 32]);
    end
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_g = (k < 5) ? 4'(1 << (k % 4)) : 4'b0000;
      exp_r = (k >= 3) ? 4'(1 << ((k - 3) % 4)) : 4'b0000;
      n_checks++; if (req_ready !== exp_g) begin n_fail++; $display("FAIL b2b_grant k=%0d: got %b expected %b", k, req_ready, exp_g); end
      n_checks++; if (resp_valid !== exp_r) begin n_fail++; $display("FAIL b2b_resp k=%0d: got %b expected %b", k, resp_valid, exp_r); end
      if (k >= 3) begin
        n_checks++; if (resp_data !== exp_d[(k - 3) % 4]) begin n_fail++; $display("FAIL b2b_data k=%0d: got %h expected %h", k, resp_data, exp_d[(k - 3) % 4]); end
      end
      @(posedge clk); #1;
      if (k == 4) req_valid = '0;
    end
  endtask

  task automatic single_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                           output logic [N-1:0] rdy, output logic [N-1:0] rv,
                           output logic [31:0] d, output logic uf, output logic of);
    req_a[32*idx +: 32] = a;
    req_b[32*idx +: 32] = b;
    req_valid = '0;
    req_valid[idx] = 1'b1;
    @(negedge clk);
    rdy = req_ready;
    @(posedge clk); #1;
    req_valid = '0;
    repeat (LAT) @(negedge clk);
    rv = resp_valid; d = resp_data; uf = resp_uf; of = resp_of;
    @(posedge clk); #1;
  endtask

  task automatic test_flags();
    logic [N-1:0] rdy, rv;
    logic [31:0]  d;
    logic         uf, of;
    single_op(1, 32'h7F00_0000, 32'h7F00_0000, rdy, rv, d, uf, of);
    n_checks++; if (rdy !== 4'b0010) begin n_fail++; $display("FAIL ovf_ready: got %b expected 0010", rdy); end
    n_checks++; if (rv !== 4'b0010) begin n_fail++; $display("FAIL ovf_resp: got %b expected 0010", rv); end
    n_checks++; if ({uf, of} !== 2'b01) begin n_fail++; $display("FAIL ovf_flags: got uf/of %b expected 01", {uf, of}); end
    n_checks++; if (d[30:23] !== 8'hFF) begin n_fail++; $display("FAIL ovf_exp: got %h expected ff", d[30:23]); end
`ifdef FMUL_ARB_STICKY_EN
    n_checks++; if (sticky_of !== 4'b0010) begin n_fail++; $display("FAIL sticky_of: got %b expected 0010", sticky_of); end
`endif
    single_op(3, 32'h0000_0000, 32'h0080_0000, rdy, rv, d, uf, of);
    n_checks++; if (rv !== 4'b1000) begin n_fail++; $display("FAIL zero_resp: got %b expected 1000", rv); end
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL zero_data: got %h expected 0", d); end
    n_checks++; if ({uf, of} !== 2'b00) begin n_fail++; $display("FAIL zero_flags: got uf/of %b expected 00", {uf, of}); end
    single_op(0, 32'h0080_0000, 32'h0080_0000, rdy, rv, d, uf, of);
    n_checks++; if (rv !== 4'b0001) begin n_fail++; $display("FAIL unf_resp: got %b expected 0001", rv); end
    n_checks++; if ({uf, of} !== 2'b10) begin n_fail++; $display("FAIL unf_flags: got uf/of %b expected 10", {uf, of}); end
  endtask

  task automatic test_random();
    exp_t         q[$];
    exp_t         e;
    int           ptr_m, gi, c;
    logic [N-1:0] pend, g;
    logic [31:0]  ea, eb;
    logic [33:0]  fp;
    rst_n = 1'b0; req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ptr_m = 0; pend = '0;
    for (int k = 0; k < 300 + LAT + 1; k++) begin
      if (k < 300) begin
        for (int i = 0; i < N; i++) begin
          if (pend[i]) begin
            if ($urandom_range(15) == 0) pend[i] = 1'b0;
          end else if ($urandom_range(1) == 1) begin
            pend[i] = 1'b1;
            req_a[32*i +: 32] = rand_op();
            req_b[32*i +: 32] = rand_op();
          end
        end
      end else begin
        pend = '0;
      end
      req_valid = pend;
      @(negedge clk);
      g = '0; gi = -1;
      for (int s = 0; s < N; s++) begin
        c = (ptr_m + s) % N;
        if (gi < 0 && pend[c]) gi = c;
      end
      ea = 32'd0; eb = 32'd0;
      if (gi >= 0) begin
        g[gi] = 1'b1;
        ea = req_a[32*gi +: 32];
        eb = req_b[32*gi +: 32];
      end
      n_checks++; if (req_ready !== g) begin n_fail++; $display("FAIL rand_grant k=%0d: got %b expected %b", k, req_ready, g); end
      n_checks++; if ({mul_a, mul_b} !== {ea, eb}) begin n_fail++; $display("FAIL rand_mul_ops k=%0d: got %h expected %h", k, {mul_a, mul_b}, {ea, eb}); end
      if (gi >= 0) begin
        fp = fp_mul(ea, eb);
        e.due = k + LAT; e.owner1h = g; e.data = fp[31:0];
        e.uf = fp[33]; e.of = fp[32];
        if (ea[30:0] == 31'd0 || eb[30:0] == 31'd0) begin
          e.uf = 1'b0; e.of = 1'b0;
        end
        q.push_back(e);
        ptr_m = (gi + 1) % N;
        pend[gi] = 1'b0;
      end
      if (q.size() > 0 && q[0].due == k) begin
        e = q.pop_front();
        n_checks++; if (resp_valid !== e.owner1h) begin n_fail++; $display("FAIL rand_resp k=%0d: got %b expected %b", k, resp_valid, e.owner1h); end
        n_checks++; if (resp_data !== e.data) begin n_fail++; $display("FAIL rand_data k=%0d: got %h expected %h", k, resp_data, e.data); end
        n_checks++; if ({resp_uf, resp_of} !== {e.uf, e.of}) begin n_fail++; $display("FAIL rand_flags k=%0d: got %b expected %b", k, {resp_uf, resp_of}, {e.uf, e.of}); end
      end else begin
        n_checks++; if (resp_valid !== '0) begin n_fail++; $display("FAIL rand_idle_resp k=%0d: got %b expected 0000", k, resp_valid); end
      end
      @(posedge clk); #1;
    end
    n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL rand_outstanding: got %0d expected 0", q.size()); end
  endtask

  task automatic test_quiesce();
    logic [31:0]  exp_d [3];
    logic [N-1:0] exp_g, exp_r;
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = {1'b1, 8'(125 + i), 23'($urandom)};
      req_b[32*i +: 32] = {1'b0, 8'd128, 23'($urandom)};
      if (i < 3) exp_d[i] = fp_mul(req_a[32*i +: 32], req_b[32*i +: 32]);
    end
    for (int k = 0; k < 10; k++) begin
      case (k)
        0: req_valid = 4'b0001;
        1: req_valid = 4'b0010;
        2: begin req_valid = 4'b0100; quiesce = 1'b1; end
        default: req_valid = 4'b1000;
      endcase
      if (k == 8) quiesce = 1'b0;
      @(negedge clk);
      exp_g = (k < 3) ? 4'(1 << k) : ((k == 9) ? 4'b1000 : 4'b0000);
      exp_r = (k >= 3 && k <= 5) ? 4'(1 << (k - 3)) : 4'b0000;
      n_checks++; if (req_ready !== exp_g) begin n_fail++; $display("FAIL qsc_grant k=%0d: got %b expected %b", k, req_ready, exp_g); end
      n_checks++; if (resp_valid !== exp_r) begin n_fail++; $display("FAIL qsc_resp k=%0d: got %b expected %b", k, resp_valid, exp_r); end
      if (k >= 3 && k <= 5) begin
        n_checks++; if (resp_data !== exp_d[k - 3]) begin n_fail++; $display("FAIL qsc_data k=%0d: got %h expected %h", k, resp_data, exp_d[k - 3]); end
      end
      n_checks++; if (idle !== (k == 7 || k == 8)) begin n_fail++; $display("FAIL qsc_idle k=%0d: got %b expected %b", k, idle, (k == 7 || k == 8)); end
      @(posedge clk); #1;
    end
    req_valid = '0;
    repeat (LAT + 1) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midflight();
    for (int k = 0; k < 3; k++) begin
      req_valid = 4'(1 << k);
      @(posedge clk); #1;
    end
    req_valid = '0;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (resp_valid !== '0) begin n_fail++; $display("FAIL mrst_resp_valid: got %b expected 0000", resp_valid); end
    n_checks++; if ({resp_data, resp_uf, resp_of} !== 34'd0) begin n_fail++; $display("FAIL mrst_resp_fields: got %h expected 0", {resp_data, resp_uf, resp_of}); end
    n_checks++; if ({mul_a, mul_b} !== 64'd0) begin n_fail++; $display("FAIL mrst_mul_ops: got %h expected 0", {mul_a, mul_b}); end
    n_checks++; if ({req_ready, idle} !== 5'd0) begin n_fail++; $display("FAIL mrst_ready_idle: got %b expected 00000", {req_ready, idle}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++; if (resp_valid !== '0) begin n_fail++; $display("FAIL mrst_ghost k=%0d: got %b expected 0000", k, resp_valid); end
      @(posedge clk); #1;
    end
    req_valid = 4'hF;
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mrst_ptr: got %b expected 0001", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (LAT + 1) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_lat1();
    test_back_to_back();
    test_flags();
    test_random();
    test_quiesce();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
